// File: rtl/tri_pkg.sv
// Shared constants and state encoding for the triangle cosine engine.
package tri_pkg;

  localparam logic [1:0] TRI_ACUTE   = 2'd0;
  localparam logic [1:0] TRI_RIGHT   = 2'd1;
  localparam logic [1:0] TRI_OBTUSE  = 2'd2;
  localparam logic [1:0] TRI_INVALID = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    DIV  = 3'd3,
    OUT  = 3'd4
  } tri_state_t;

endpackage

// File: rtl/tri_seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// The first step runs in the start cycle, so a result is ready QB cycles after start.
module tri_seq_div #(
  parameter int NUM_W = 17,
  parameter int DEN_W = 17,
  parameter int QB    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [QB-1:0]    quo
);

  localparam int REM_W = DEN_W + 1;
  localparam int CNT_W = $clog2(QB + 1);

  logic [REM_W-1:0] rem_q, rem_d, rem_src, rem_sub;
  logic [QB-1:0]    quo_q, quo_d, quo_src;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ge;

  // The numerator never exceeds the denominator, so the remainder stays below 2*den.
  always_comb begin
    rem_src = start ? REM_W'(num) : rem_q;
    quo_src = start ? '0 : quo_q;
    ge      = (rem_src >= {1'b0, den});
    rem_sub = ge ? (rem_src - {1'b0, den}) : rem_src;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start || busy_q) begin
      rem_d  = rem_sub << 1;
      quo_d  = (quo_src << 1) | QB'(ge);
      cnt_d  = (start ? CNT_W'(QB) : cnt_q) - CNT_W'(1);
      busy_d = (cnt_d != '0);
      done_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quo  = quo_q;

endmodule

// File: rtl/triangle_cos_engine.sv
// Classifies a triangle from three streamed sides and emits the three angle cosines (Q2.(COS_W-2)).
// Define TRI_ROUND_EN for round-half-away-from-zero cosines (one extra divider cycle per angle).
module triangle_cos_engine
  import tri_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int COS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN_W-1:0] in_length,
  output logic             out_valid,
  output logic [COS_W-1:0] out_cos,
  output logic [1:0]       out_tri,
  output logic [1:0]       out_idx,
  output tri_state_t       dbg_state
);

  // Handshake: a side is taken on any rising edge where in_valid && in_ready; out_valid has no ready.
  localparam int SQ_W  = 2 * LEN_W;
  localparam int NUM_W = 2 * LEN_W + 2;
  localparam int DEN_W = 2 * LEN_W + 1;
  localparam int SUM_W = LEN_W + 1;
`ifdef TRI_ROUND_EN
  localparam int QB = COS_W;
`else
  localparam int QB = COS_W - 1;
`endif
  localparam int STEP_W = $clog2(QB);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(QB - 1);

  tri_state_t        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [LEN_W-1:0]  side_q [3];
  logic [LEN_W-1:0]  side_d [3];
  logic [NUM_W-1:0]  num_q  [3];
  logic [NUM_W-1:0]  num_d  [3];
  logic [DEN_W-1:0]  den_q  [3];
  logic [DEN_W-1:0]  den_d  [3];
  logic [COS_W-1:0]  cos_q  [3];
  logic [COS_W-1:0]  cos_d  [3];
  logic [1:0]        class_q, class_d;
  logic [1:0]        ang_q, ang_d;
  logic [1:0]        cap_q, cap_d;
  logic [1:0]        out_cnt_q, out_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic [SQ_W-1:0]   sq     [3];
  logic [NUM_W-1:0]  n_calc [3];
  logic [DEN_W-1:0]  d_calc [3];
  logic [SUM_W-1:0]  sum_ab, sum_bc, sum_ac;
  logic [1:0]        class_calc;
  logic              bad, neg, zero, accept;

  logic              div_start, div_done;
  logic [DEN_W-1:0]  div_num, div_den;
  logic [QB-1:0]     div_quo;
  logic [NUM_W-1:0]  sel_num;
  logic [COS_W-1:0]  cos_mag, cos_val;

  always_comb begin
    for (int i = 0; i < 3; i++) sq[i] = SQ_W'(side_q[i]) * SQ_W'(side_q[i]);
    n_calc[0] = NUM_W'(sq[1]) + NUM_W'(sq[2]) - NUM_W'(sq[0]);
    n_calc[1] = NUM_W'(sq[0]) + NUM_W'(sq[2]) - NUM_W'(sq[1]);
    n_calc[2] = NUM_W'(sq[0]) + NUM_W'(sq[1]) - NUM_W'(sq[2]);
    d_calc[0] = {SQ_W'(side_q[1]) * SQ_W'(side_q[2]), 1'b0};
    d_calc[1] = {SQ_W'(side_q[0]) * SQ_W'(side_q[2]), 1'b0};
    d_calc[2] = {SQ_W'(side_q[0]) * SQ_W'(side_q[1]), 1'b0};
    sum_ab = SUM_W'(side_q[0]) + SUM_W'(side_q[1]);
    sum_bc = SUM_W'(side_q[1]) + SUM_W'(side_q[2]);
    sum_ac = SUM_W'(side_q[0]) + SUM_W'(side_q[2]);
    bad  = (side_q[0] == '0) || (side_q[1] == '0) || (side_q[2] == '0) ||
           (sum_ab <= SUM_W'(side_q[2])) || (sum_bc <= SUM_W'(side_q[0])) ||
           (sum_ac <= SUM_W'(side_q[1]));
    neg  = n_calc[0][NUM_W-1] | n_calc[1][NUM_W-1] | n_calc[2][NUM_W-1];
    zero = (n_calc[0] == '0) | (n_calc[1] == '0) | (n_calc[2] == '0);
    if (bad)       class_calc = TRI_INVALID;
    else if (neg)  class_calc = TRI_OBTUSE;
    else if (zero) class_calc = TRI_RIGHT;
    else           class_calc = TRI_ACUTE;
  end

  // Divider operands for the angle in flight; the result is signed by the captured numerator.
  always_comb begin
    sel_num   = num_q[ang_q];
    div_num   = DEN_W'(sel_num[NUM_W-1] ? -sel_num : sel_num);
    div_den   = den_q[ang_q];
    div_start = (state_q == DIV) && (step_q == '0);
`ifdef TRI_ROUND_EN
    cos_mag = COS_W'(({1'b0, div_quo} + (QB + 1)'(1)) >> 1);
`else
    cos_mag = COS_W'(div_quo);
`endif
    cos_val = num_q[cap_q][NUM_W-1] ? -cos_mag : cos_mag;
  end

  tri_seq_div #(
    .NUM_W (DEN_W),
    .DEN_W (DEN_W),
    .QB    (QB)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quo   (div_quo)
  );

  assign in_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    side_d    = side_q;
    num_d     = num_q;
    den_d     = den_q;
    cos_d     = cos_q;
    class_d   = class_q;
    ang_d     = ang_q;
    cap_d     = cap_q;
    out_cnt_d = out_cnt_q;
    step_d    = step_q;
    case (state_q)
      IDLE: if (accept) begin
        side_d[0] = in_length;
        beat_d    = 2'd1;
        state_d   = LOAD;
      end
      LOAD: if (accept) begin
        side_d[beat_q] = in_length;
        beat_d         = beat_q + 2'd1;
        if (beat_q == 2'd2) state_d = CALC;
      end
      CALC: begin
        num_d   = n_calc;
        den_d   = d_calc;
        class_d = class_calc;
        ang_d   = 2'd0;
        cap_d   = 2'd0;
        step_d  = '0;
        if (class_calc == TRI_INVALID) begin
          for (int i = 0; i < 3; i++) cos_d[i] = '0;
          state_d = OUT;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          ang_d  = ang_q + 2'd1;
          if (ang_q == 2'd2) state_d = OUT;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      OUT: begin
        if (out_cnt_q == 2'd2) begin
          out_cnt_d = 2'd0;
          state_d   = IDLE;
        end else begin
          out_cnt_d = out_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The last quotient lands in the first OUT cycle, before its index is displayed.
    if (div_done) begin
      cos_d[cap_q] = cos_val;
      cap_d        = cap_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 2'd0;
      class_q   <= TRI_ACUTE;
      ang_q     <= 2'd0;
      cap_q     <= 2'd0;
      out_cnt_q <= 2'd0;
      step_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        side_q[i] <= '0;
        num_q[i]  <= '0;
        den_q[i]  <= '0;
        cos_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      class_q   <= class_d;
      ang_q     <= ang_d;
      cap_q     <= cap_d;
      out_cnt_q <= out_cnt_d;
      step_q    <= step_d;
      side_q    <= side_d;
      num_q     <= num_d;
      den_q     <= den_d;
      cos_q     <= cos_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_idx   = out_cnt_q;
  assign out_cos   = cos_q[out_cnt_q];
  assign out_tri   = class_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_triangle_cos_engine.sv
// Directed bench for triangle_cos_engine: driver tasks feed sides, a monitor checks outputs against a queue.
module tb_triangle_cos_engine;
  import tri_pkg::*;

  localparam int LEN_W = 8;
  localparam int COS_W = 16;
`ifdef TRI_ROUND_EN
  localparam int QB = COS_W;
  localparam logic [COS_W-1:0] COS_334_A = 16'h2AAB;
`else
  localparam int QB = COS_W - 1;
  localparam logic [COS_W-1:0] COS_334_A = 16'h2AAA;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [LEN_W-1:0] in_length;
  logic             out_valid;
  logic [COS_W-1:0] out_cos;
  logic [1:0]       out_tri;
  logic [1:0]       out_idx;
  tri_state_t       dbg_state;

  triangle_cos_engine #(.LEN_W(LEN_W), .COS_W(COS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_length (in_length),
    .out_valid (out_valid),
    .out_cos   (out_cos),
    .out_tri   (out_tri),
    .out_idx   (out_idx),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {class, idx, cos} per output beat, plus the expected cycle of each idx-0 beat
  logic [COS_W+3:0] exp_q[$];
  int               lat_q[$];
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    logic [COS_W+3:0] e;
    int               l;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out_valid: idx %0d cos 0x%0h at cycle %0d", out_idx, out_cos, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_tri", 32'(out_tri), 32'(e[COS_W+3:COS_W+2]));
          check("out_idx", 32'(out_idx), 32'(e[COS_W+1:COS_W]));
          check("out_cos", 32'(out_cos), 32'(e[COS_W-1:0]));
          if (e[COS_W+1:COS_W] == 2'd0 && lat_q.size() > 0) begin
            l = lat_q.pop_front();
            check("first_valid_cycle", 32'(cyc), 32'(l));
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic send_beat(input logic [LEN_W-1:0] len, output int t);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_length = len;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("in_ready_timeout", 32'(in_ready), 32'd1);
    t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_tri(input logic [LEN_W-1:0] a, input logic [LEN_W-1:0] b,
                          input logic [LEN_W-1:0] c, input int gap, input int hold,
                          input bit chk, input logic [1:0] tri_c,
                          input logic [COS_W-1:0] c0, input logic [COS_W-1:0] c1,
                          input logic [COS_W-1:0] c2);
    int t;
    if (chk) begin
      exp_q.push_back({tri_c, 2'd0, c0});
      exp_q.push_back({tri_c, 2'd1, c1});
      exp_q.push_back({tri_c, 2'd2, c2});
    end
    send_beat(a, t);
    repeat (gap) @(negedge clk);
    send_beat(b, t);
    repeat (gap) @(negedge clk);
    send_beat(c, t);
    if (chk) lat_q.push_back(t + 2 + ((tri_c == TRI_INVALID) ? 0 : 3 * QB));
    if (hold > 0) begin
      in_valid  = 1'b1;
      in_length = 8'hAA;
      repeat (hold) begin
        @(negedge clk);
        check("in_ready_while_busy", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_length = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_cos", 32'(out_cos), 32'd0);
    check("reset_out_tri", 32'(out_tri), 32'd0);
    check("reset_out_idx", 32'(out_idx), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    send_tri(8'd3, 8'd4, 8'd5, 0, 0, 1'b1, TRI_RIGHT, 16'h3333, 16'h2666, 16'h0000);
    send_tri(8'd5, 8'd5, 8'd5, 0, 0, 1'b1, TRI_ACUTE, 16'h2000, 16'h2000, 16'h2000);
    send_tri(8'd2, 8'd3, 8'd4, 0, 0, 1'b1, TRI_OBTUSE, 16'h3800, 16'h2C00, 16'hF000);
    send_tri(8'd1, 8'd2, 8'd3, 0, 0, 1'b1, TRI_INVALID, 16'h0000, 16'h0000, 16'h0000);
    send_tri(8'd0, 8'd5, 8'd5, 0, 0, 1'b1, TRI_INVALID, 16'h0000, 16'h0000, 16'h0000);
    send_tri(8'd3, 8'd3, 8'd4, 2, 20, 1'b1, TRI_ACUTE, COS_334_A, COS_334_A, 16'h071C);
    send_tri(8'd255, 8'd255, 8'd255, 1, 0, 1'b1, TRI_ACUTE, 16'h2000, 16'h2000, 16'h2000);
    drain();

    // Abort a triangle mid-DIV; nothing may come out of it
    send_tri(8'd3, 8'd4, 8'd5, 0, 0, 1'b0, TRI_RIGHT, 16'h0, 16'h0, 16'h0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_abort_state", 32'(dbg_state), 32'(IDLE));
    check("post_abort_in_ready", 32'(in_ready), 32'd1);
    repeat (60) @(negedge clk);

    send_tri(8'd3, 8'd4, 8'd5, 0, 0, 1'b1, TRI_RIGHT, 16'h3333, 16'h2666, 16'h0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
